// File: rtl/program_loader.sv
// program_loader: receives a serial program image (16-bit word count followed by
// the words, high byte first) and writes it into instruction memory while holding
// the processor in reset. cpu_hold is released only after a complete, valid load.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte
// (XOR of every preceding byte, count bytes included) before the load is accepted.

module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // WR_LAST covers the cycle in which the final word's write strobe is out, so
    // that done rises only after the last word has actually been written.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CNT_HI  = 4'd1,
        CNT_LO  = 4'd2,
        DAT_HI  = 4'd3,
        DAT_LO  = 4'd4,
        WR_LAST = 4'd5,
        DONE    = 4'd6,
        ERR     = 4'd7
`ifdef LOADER_CHECKSUM_EN
        ,
        CHK     = 4'd8
`endif
    } state_t;

    // Largest legal word count; counts are compared in 17 bits so that a full
    // 2^16-word memory would still be representable.
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    state_t            state;
    state_t            next_state;
    logic              xfer;
    logic              restart;
    logic [7:0]        cnt_hi;
    logic [7:0]        data_hi;
    logic [15:0]       count_n;
    logic              count_zero;
    logic              count_big;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer       = byte_valid & byte_ready;
    assign restart    = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign count_n    = {cnt_hi, byte_in};
    assign count_zero = (count_n == 16'd0);
    assign count_big  = ({1'b0, count_n} > CAPACITY);
    assign last_word  = (word_idx == last_idx);

    // State register.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every loading state advances only on an accepted byte.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = CNT_HI;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    next_state = CNT_LO;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    if (count_zero) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CHK;
`else
                        next_state = DONE;
`endif
                    end else if (count_big) begin
                        next_state = ERR;
                    end else begin
                        next_state = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    next_state = DAT_LO;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CHK;
`else
                        next_state = WR_LAST;
`endif
                    end else begin
                        next_state = DAT_HI;
                    end
                end
            end
            WR_LAST: begin
                next_state = DONE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (byte_in == csum) begin
                        next_state = DONE;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs decoded purely from the current state.
    always_comb begin
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            CNT_HI, CNT_LO, DAT_HI, DAT_LO: begin
                byte_ready = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
            end
`endif
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    // Datapath: latch count and high byte, then issue a registered one-cycle write
    // for each completed word; address and data hold between writes.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            word_idx <= '0;
            last_idx <= '0;
            cnt_hi   <= '0;
            data_hi  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                word_idx <= '0;
            end
            if (xfer) begin
                case (state)
                    CNT_HI: begin
                        cnt_hi <= byte_in;
                    end
                    CNT_LO: begin
                        last_idx <= ADDR_W'(count_n - 16'd1);
                    end
                    DAT_HI: begin
                        data_hi <= byte_in;
                    end
                    DAT_LO: begin
                        mem_we   <= 1'b1;
                        mem_addr <= word_idx;
                        mem_data <= {data_hi, byte_in};
                        word_idx <= word_idx + ADDR_W'(1);
                    end
                    default: begin
                        mem_we <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every accepted byte up to (not including) the checksum.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            csum <= '0;
        end else if (restart) begin
            csum <= '0;
        end else if (xfer && (state != CHK)) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized bench for program_loader.
// Builds byte streams, drives them with the valid/ready handshake, captures every
// memory write, and compares against a stream-level model of the load rules.
// Honours LOADER_CHECKSUM_EN when the design is built with it.

module tb_program_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clock;
    logic              resetn;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]        stream[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]       wr_data_q[$];

    typedef struct {
        logic [15:0] count;
        bit          throttle;
        bit          corrupt;
        int          exp_writes;
        bit          exp_done;
        bit          exp_error;
    } vec_t;

    vec_t vec[8];

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every write strobe mid-cycle.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Count bytes, then 2*count random data bytes, then (if enabled) the checksum.
    task automatic build_stream(input logic [15:0] count, input bit corrupt);
        logic [7:0] x;
        stream.delete();
        stream.push_back(count[15:8]);
        stream.push_back(count[7:0]);
        if (int'(count) <= CAP) begin
            for (int i = 0; i < 2 * int'(count); i++) begin
                stream.push_back(8'($urandom));
            end
            if (CS_EN) begin
                x = 8'h00;
                foreach (stream[i]) x ^= stream[i];
                stream.push_back(x ^ {7'd0, corrupt});
            end
        end
    endtask

    task automatic start_load();
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_output("start_clears_done", done, 1'b0);
        check_output("start_clears_error", error, 1'b0);
        check_output("start_ready", byte_ready, 1'b1);
    endtask

    // Send the first n_send bytes of stream; optionally throttle and pulse start mid-load.
    task automatic apply_stimulus(input bit throttle, input bit pulse_start, input int n_send);
        int  i      = 0;
        int  cyc    = 0;
        int  limit  = 4 * n_send + 40;
        bit  tog    = 1'b0;
        bit  pulsed = 1'b0;
        bit  acc;
        while (i < n_send && cyc < limit) begin
            @(negedge clock);
            tog        = ~tog;
            byte_valid = throttle ? tog : 1'b1;
            byte_in    = stream[i];
            start      = 1'b0;
            if (pulse_start && !pulsed && i == n_send / 2) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            acc = byte_valid && byte_ready;
            @(posedge clock);
            if (acc) i++;
            cyc++;
        end
        #1;
        byte_valid = 1'b0;
        start      = 1'b0;
        if (i < n_send) check_output("send_timeout", i, n_send);
    endtask

    task automatic wait_finish();
        int k = 0;
        while (!(done || error) && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_output("finish_seen", (done || error), 1'b1);
        @(negedge clock);
    endtask

    // Reference: derive expected writes and outcome from the stream rules alone.
    task automatic compare_model(input string name);
        int         n;
        bit         too_big;
        int         exp_w;
        logic [7:0] x;
        bit         cs_ok;
        bit         exp_done;
        logic [ADDR_W-1:0] a;
        n       = int'({stream[0], stream[1]});
        too_big = (n > CAP);
        exp_w   = too_big ? 0 : n;
        cs_ok   = 1'b1;
        if (CS_EN && !too_big) begin
            x = 8'h00;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= stream[i];
            cs_ok = (stream[2 + 2 * n] == x);
        end
        exp_done = !too_big && cs_ok;
        check_output({name, "_nwrites"}, wr_addr_q.size(), exp_w);
        for (int i = 0; i < exp_w && i < wr_addr_q.size(); i++) begin
            a = ADDR_W'(i);
            check_output($sformatf("%s_addr%0d", name, i), wr_addr_q[i], a);
            check_output($sformatf("%s_data%0d", name, i), wr_data_q[i], {stream[2 + 2 * i], stream[3 + 2 * i]});
        end
        check_output({name, "_done"}, done, exp_done);
        check_output({name, "_error"}, error, !exp_done);
        check_output({name, "_cpu_hold"}, cpu_hold, !exp_done);
        check_output({name, "_ready"}, byte_ready, 1'b0);
    endtask

    task automatic set_fixed_stream(input logic [7:0] cs);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        if (CS_EN) stream.push_back(cs);
    endtask

    initial begin
        logic [15:0] cnt;
        resetn     = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        vec[0] = '{16'd2,    1'b0, 1'b0, 2,   1'b1,   1'b0};
        vec[1] = '{16'd0,    1'b0, 1'b0, 0,   1'b1,   1'b0};
        vec[2] = '{16'd1,    1'b1, 1'b0, 1,   1'b1,   1'b0};
        vec[3] = '{16'h0101, 1'b0, 1'b0, 0,   1'b0,   1'b1};
        vec[4] = '{16'h0100, 1'b0, 1'b0, 256, 1'b1,   1'b0};
        vec[5] = '{16'd5,    1'b1, 1'b0, 5,   1'b1,   1'b0};
        vec[6] = '{16'hFFFF, 1'b0, 1'b0, 0,   1'b0,   1'b1};
        vec[7] = '{16'd3,    1'b0, 1'b1, 3,   !CS_EN, CS_EN};

        // Reset values.
        repeat (3) @(negedge clock);
        check_output("rst_mem_we", mem_we, 1'b0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_data", mem_data, 0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_error", error, 1'b0);
        check_output("rst_ready", byte_ready, 1'b0);
        check_output("rst_cpu_hold", cpu_hold, 1'b1);
        resetn = 1'b0;

        // byte_valid without a start in IDLE does nothing.
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (4) @(negedge clock);
        byte_valid = 1'b0;
        check_output("idle_ready", byte_ready, 1'b0);
        check_output("idle_cpu_hold", cpu_hold, 1'b1);
        check_output("idle_nwrites", wr_addr_q.size(), 0);

        // Fixed stream 00 02 12 34 AB CD (+0x42 checksum) with exact timing.
        set_fixed_stream(8'h42);
        start_load();
        apply_stimulus(1'b0, 1'b0, stream.size());
`ifdef LOADER_CHECKSUM_EN
        @(negedge clock);
        check_output("fixed_done_cycle", done, 1'b1);
        check_output("fixed_we_after", mem_we, 1'b0);
`else
        @(negedge clock);
        check_output("fixed_last_we", mem_we, 1'b1);
        check_output("fixed_last_addr", mem_addr, 1);
        check_output("fixed_last_data", mem_data, 16'hABCD);
        check_output("fixed_done_early", done, 1'b0);
        @(negedge clock);
        check_output("fixed_done", done, 1'b1);
        check_output("fixed_cpu_hold", cpu_hold, 1'b0);
        check_output("fixed_we_off", mem_we, 1'b0);
        check_output("fixed_addr_hold", mem_addr, 1);
        check_output("fixed_data_hold", mem_data, 16'hABCD);
`endif
        wait_finish();
        check_output("fixed_w0", (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx, 16'h1234);
        check_output("fixed_w1", (wr_data_q.size() > 1) ? wr_data_q[1] : 16'hxxxx, 16'hABCD);
        compare_model("fixed");

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: words stay written, load reports an error.
        set_fixed_stream(8'h43);
        start_load();
        apply_stimulus(1'b0, 1'b0, stream.size());
        wait_finish();
        check_output("badcs_error", error, 1'b1);
        check_output("badcs_cpu_hold", cpu_hold, 1'b1);
        check_output("badcs_nwrites", wr_addr_q.size(), 2);
        compare_model("badcs");
`endif

        // Table of count / throttle / checksum-corruption cases.
        for (int v = 0; v < 8; v++) begin
            build_stream(vec[v].count, vec[v].corrupt);
            start_load();
            apply_stimulus(vec[v].throttle, 1'b0, stream.size());
            wait_finish();
            check_output($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), vec[v].exp_writes);
            check_output($sformatf("vec%0d_done", v), done, vec[v].exp_done);
            check_output($sformatf("vec%0d_error", v), error, vec[v].exp_error);
            compare_model($sformatf("vec%0d", v));
        end

        // Reset after the third data byte, then a clean reload from address 0.
        set_fixed_stream(8'h42);
        start_load();
        apply_stimulus(1'b0, 1'b0, 5);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check_output("midrst_mem_we", mem_we, 1'b0);
        check_output("midrst_mem_addr", mem_addr, 0);
        check_output("midrst_mem_data", mem_data, 0);
        check_output("midrst_done", done, 1'b0);
        check_output("midrst_error", error, 1'b0);
        check_output("midrst_ready", byte_ready, 1'b0);
        check_output("midrst_cpu_hold", cpu_hold, 1'b1);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clock);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check_output("midrst_no_write", wr_addr_q.size(), 0);
        check_output("midrst_idle_ready", byte_ready, 1'b0);
        start_load();
        apply_stimulus(1'b0, 1'b0, stream.size());
        wait_finish();
        compare_model("reload");

        // Throttled stream with a start pulse mid-load.
        set_fixed_stream(8'h42);
        start_load();
        apply_stimulus(1'b1, 1'b1, stream.size());
        wait_finish();
        check_output("throttle_w0", (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx, 16'h1234);
        check_output("throttle_w1", (wr_data_q.size() > 1) ? wr_data_q[1] : 16'hxxxx, 16'hABCD);
        compare_model("throttle");

        // Randomized loads.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 9))
                0:       cnt = 16'd0;
                1:       cnt = 16'h0100;
                2:       cnt = 16'($urandom_range(257, 65535));
                default: cnt = 16'($urandom_range(1, 40));
            endcase
            build_stream(cnt, 1'($urandom_range(0, 3) == 0));
            start_load();
            apply_stimulus(1'($urandom), 1'($urandom), stream.size());
            wait_finish();
            compare_model($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
